// File: rtl/prime_sweep_ctrl.sv
// Sweeps 4-bit codes LO..HI by STEP through the external prime detector and collects the prime count.
// Optional per-code prime bitmap is built only when PRIME_SWEEP_MAP_EN is defined.
module prime_sweep_ctrl #(
    parameter int unsigned LO   = 0,
    parameter int unsigned HI   = 15,
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    input  logic        f_in,
    output logic [3:0]  code_out,
    output logic        en_out,
    output logic        busy,
    output logic        done,
    output logic [4:0]  prime_cnt,
    output logic [3:0]  last_prime,
    output logic [15:0] prime_map,
    output logic [1:0]  state_dbg
);

    // Handshake: start is a level sampled only in IDLE; busy covers DRIVE/SAMPLE;
    // done is high for the single FIN cycle, after which results stay valid until the next start.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    localparam logic [3:0] LO4       = 4'(LO);
    localparam logic [4:0] HI5       = 5'(HI);
    localparam logic [4:0] STEP5     = 5'(STEP);
    localparam logic       EMPTY     = (LO > HI);

    state_t     state;
    state_t     state_nx;
    logic [4:0] next_code;
    logic       sweep_end;

    // Five-bit sum so a step past 15 ends the sweep instead of wrapping.
    assign next_code = {1'b0, code_out} + STEP5;
    assign sweep_end = next_code[4] || (next_code > HI5);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        en_out   = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = EMPTY ? S_FIN : S_DRIVE;
                end
            end
            S_DRIVE: begin
                en_out = 1'b1;
                if (!hold) begin
                    state_nx = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                en_out = 1'b1;
                if (!hold) begin
                    state_nx = sweep_end ? S_FIN : S_DRIVE;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy      = en_out;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            code_out   <= LO4;
            prime_cnt  <= 5'd0;
            last_prime <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        code_out   <= LO4;
                        prime_cnt  <= 5'd0;
                        last_prime <= 4'd0;
                    end
                end
                S_SAMPLE: begin
                    if (!hold) begin
                        if (f_in) begin
                            prime_cnt  <= prime_cnt + 5'd1;
                            last_prime <= code_out;
                        end
                        if (!sweep_end) begin
                            code_out <= next_code[3:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PRIME_SWEEP_MAP_EN
    logic [15:0] map_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            map_q <= 16'h0000;
        end else if (state == S_IDLE && start) begin
            map_q <= 16'h0000;
        end else if (state == S_SAMPLE && !hold && f_in) begin
            map_q[code_out] <= 1'b1;
        end
    end

    assign prime_map = map_q;
`else
    assign prime_map = 16'h0000;
`endif

endmodule
